// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, n data bits, stop bit.
// Deserializes on bit_tick and hands words out over valid/ready.
module serial_frame_receiver #(
  parameter int n         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_tick,
  input  logic         serial_in,
  input  logic         data_ready,
  input  logic         clear_err,
  output logic [n-1:0] data_out,
  output logic         data_valid,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [n-1:0]  sr_q;
  logic [n-1:0]  sr_d;
  logic          busy_q;

  logic [n-1:0]  data_q;
  logic          valid_q;
  logic          valid_d;
  logic          ferr_q;
  logic          ferr_d;
  logic          ovr_q;
  logic          ovr_d;

  logic          stop_tick;
  logic          load;
  logic          drop;
  logic          bad_stop;
  logic          accept;

  // Next shift value and handshake/flag next-state decisions
  always_comb begin
    sr_d = sr_q;
    if (LSB_FIRST) begin
      sr_d = {serial_in, sr_q[n-1:1]};
    end else begin
      sr_d = {sr_q[n-2:0], serial_in};
    end

    stop_tick = bit_tick && (state_q == STOP);
    accept    = valid_q && data_ready;
    load      = stop_tick && serial_in &&
                (!valid_q || data_ready);
    drop      = stop_tick && serial_in &&
                valid_q && !data_ready;
    bad_stop  = stop_tick && !serial_in;

    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    // A set event in the same cycle as clear_err wins
    ferr_d = ferr_q;
    if (bad_stop) begin
      ferr_d = 1'b1;
    end else if (clear_err) begin
      ferr_d = 1'b0;
    end

    ovr_d = ovr_q;
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clear_err) begin
      ovr_d = 1'b0;
    end
  end

  // Frame FSM: advances only on bit_tick, holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
    end else if (bit_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!serial_in) begin
            state_q <= DATA;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DATA: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output word register, valid flag and sticky errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (load) begin
        data_q <= sr_q;
      end
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: LSB-first and MSB-first
// instances share one serial stream and handshake.
module tb_serial_frame_receiver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bit_tick = 1'b0;
  logic serial_in = 1'b1;
  logic data_ready = 1'b0;
  logic clear_err = 1'b0;

  logic [7:0] l_out, m_out;
  logic l_v, l_busy, l_fe, l_ovr;
  logic m_v, m_busy, m_fe, m_ovr;

  int errors = 0;
  int checks = 0;

  serial_frame_receiver #(.n(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .bit_tick(bit_tick),
    .serial_in(serial_in), .data_ready(data_ready),
    .clear_err(clear_err), .data_out(l_out),
    .data_valid(l_v), .busy(l_busy),
    .frame_err(l_fe), .overrun(l_ovr)
  );

  serial_frame_receiver #(.n(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .bit_tick(bit_tick),
    .serial_in(serial_in), .data_ready(data_ready),
    .clear_err(clear_err), .data_out(m_out),
    .data_valid(m_v), .busy(m_busy),
    .frame_err(m_fe), .overrun(m_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seq;
    logic       stop;
    logic [7:0] exp_l;
    logic [7:0] exp_m;
    logic       exp_v;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic send_bit(input logic b,
                          input logic rdy,
                          input logic noise,
                          input logic clr);
    bit_tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      serial_in = noise ? k[0] : b;
      cyc();
    end
    serial_in  = b;
    bit_tick   = 1'b1;
    data_ready = rdy;
    clear_err  = clr;
    cyc();
    bit_tick   = 1'b0;
    data_ready = 1'b0;
    clear_err  = 1'b0;
    serial_in  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] seq,
                            input logic stop,
                            input logic rdy,
                            input logic noise);
    send_bit(1'b0, 1'b0, noise, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(seq[i], 1'b0, noise, 1'b0);
    end
    send_bit(stop, rdy, noise, 1'b0);
  endtask

  initial begin
    // seq[i] is the i-th data bit on the wire
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h80, 1'b1, 8'h80, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h11, 1'b1, 8'h11, 8'h88, 1'b1, 1'b0};
    vecs[4] = '{8'hF0, 1'b1, 8'hF0, 8'h0F, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 8'h01, 8'h80, 1'b1, 1'b0};

    reset = 1'b1;
    #2;
    chk("rst_l_out", l_out, 8'h00);
    chk("rst_m_out", m_out, 8'h00);
    chk("rst_valid", {6'd0, l_v, m_v}, 8'h00);
    chk("rst_busy", {6'd0, l_busy, m_busy}, 8'h00);
    chk("rst_ferr", {6'd0, l_fe, m_fe}, 8'h00);
    chk("rst_ovr", {6'd0, l_ovr, m_ovr}, 8'h00);
    cyc();
    reset = 1'b0;
    cyc();

    for (int r = 0; r < 6; r++) begin
      do_reset();
      send_frame(vecs[r].seq, vecs[r].stop, 1'b0, 1'b0);
      chk($sformatf("v%0d_l_out", r), l_out, vecs[r].exp_l);
      chk($sformatf("v%0d_m_out", r), m_out, vecs[r].exp_m);
      chk($sformatf("v%0d_valid", r), {6'd0, l_v, m_v},
          {6'd0, vecs[r].exp_v, vecs[r].exp_v});
      chk($sformatf("v%0d_ferr", r), {6'd0, l_fe, m_fe},
          {6'd0, vecs[r].exp_fe, vecs[r].exp_fe});
      chk($sformatf("v%0d_busy", r), {6'd0, l_busy, m_busy}, 8'h00);
      chk($sformatf("v%0d_ovr", r), {6'd0, l_ovr, m_ovr}, 8'h00);
      if (vecs[r].exp_v) begin
        cyc();
        chk($sformatf("v%0d_hold", r), l_out, vecs[r].exp_l);
        data_ready = 1'b1;
        cyc();
        data_ready = 1'b0;
        chk($sformatf("v%0d_drain", r), {6'd0, l_v, m_v}, 8'h00);
      end
      if (vecs[r].exp_fe) begin
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        chk($sformatf("v%0d_clr", r), {6'd0, l_fe, m_fe}, 8'h00);
      end
    end

    // Latency and busy timing around start/stop ticks
    do_reset();
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_busy_up", {6'd0, l_busy, m_busy}, 8'h03);
    for (int i = 0; i < 8; i++) begin
      send_bit(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("lat_pre_valid", {6'd0, l_v, m_v}, 8'h00);
    chk("lat_pre_busy", {6'd0, l_busy, m_busy}, 8'h03);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lat_valid", {6'd0, l_v, m_v}, 8'h03);
    chk("lat_busy_dn", {6'd0, l_busy, m_busy}, 8'h00);
    chk("lat_l_out", l_out, 8'h55);
    chk("lat_m_out", m_out, 8'hAA);

    // Set wins over clear_err on the same edge
    do_reset();
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    end
    send_bit(1'b0, 1'b0, 1'b0, 1'b1);
    chk("setwins_ferr", {6'd0, l_fe, m_fe}, 8'h03);

    // Overrun: second word dropped while first pending
    do_reset();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    chk("ovr_l_out", l_out, 8'h11);
    chk("ovr_m_out", m_out, 8'h88);
    chk("ovr_flag", {6'd0, l_ovr, m_ovr}, 8'h03);
    chk("ovr_valid", {6'd0, l_v, m_v}, 8'h03);
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    chk("ovr_clr", {6'd0, l_ovr, m_ovr}, 8'h00);

    // Accept and load on the same stop-tick cycle
    do_reset();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    chk("acc_l_out", l_out, 8'h22);
    chk("acc_m_out", m_out, 8'h44);
    chk("acc_valid", {6'd0, l_v, m_v}, 8'h03);
    chk("acc_ovr", {6'd0, l_ovr, m_ovr}, 8'h00);

    // Reset mid-frame with a pending word
    do_reset();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("mid_busy", {6'd0, l_busy, m_busy}, 8'h03);
    reset = 1'b1;
    #1;
    chk("mid_l_out", l_out, 8'h00);
    chk("mid_valid", {6'd0, l_v, m_v}, 8'h00);
    chk("mid_busy0", {6'd0, l_busy, m_busy}, 8'h00);
    chk("mid_flags", {4'd0, l_fe, m_fe, l_ovr, m_ovr}, 8'h00);
    cyc();
    reset = 1'b0;
    cyc();
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    chk("mid_f0_l", l_out, 8'hF0);
    chk("mid_f0_m", m_out, 8'h0F);

    // Line low with no ticks: no frame starts
    do_reset();
    serial_in = 1'b0;
    repeat (20) cyc();
    chk("notick_busy", {6'd0, l_busy, m_busy}, 8'h00);
    serial_in = 1'b1;
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    chk("notick_idle", {6'd0, l_busy, m_busy}, 8'h00);

    // Line toggling between ticks is ignored
    send_frame(8'h3A, 1'b1, 1'b0, 1'b1);
    chk("noise_l_out", l_out, 8'h3A);
    chk("noise_m_out", m_out, 8'h5C);
    chk("noise_flags", {4'd0, l_fe, m_fe, l_ovr, m_ovr}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
